// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter sharing one AXI master port among NUM_INPUTS requesters.
// Read and write channels have independent grant FSMs, so one requester can
// hold the read channel while another (or the same one) holds the write channel.

package axi_rr_pkg;

  typedef struct packed {
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi_req;

  typedef struct packed {
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
  } axi_resp;

endpackage

module axi_rr_arbiter
  import axi_rr_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  axi_req  [NUM_INPUTS-1:0] ireqs,
  input  axi_resp                  oresp,
  output axi_resp [NUM_INPUTS-1:0] iresps,
  output axi_req                   oreq,
  output logic                     rbusy,
  output logic                     wbusy,
  output logic    [IDX_W-1:0]      rgnt,
  output logic    [IDX_W-1:0]      wgnt
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_e;

  rstate_e               r_state_q, r_state_d;
  wstate_e               w_state_q, w_state_d;
  logic [IDX_W-1:0]      rgnt_q, rgnt_d, rptr_q, rptr_d;
  logic [IDX_W-1:0]      wgnt_q, wgnt_d, wptr_q, wptr_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [NUM_INPUTS-1:0] ar_req, aw_req;
  logic [IDX_W:0]        r_pick, w_pick;
  logic                  ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;

  // Returns {found, index}: first requester at or above ptr, else lowest one.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                             input logic [IDX_W-1:0]      ptr);
    logic             lo_found, hi_found;
    logic [IDX_W-1:0] lo_sel, hi_sel;
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_sel   = '0;
    hi_sel   = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_sel   = IDX_W'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_sel   = IDX_W'(i);
        end
      end
    end
    return hi_found ? {1'b1, hi_sel} : {lo_found, lo_sel};
  endfunction

  // Pointer value one past idx, wrapping at NUM_INPUTS.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= NUM_INPUTS - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Collect per-requester address-valid bits for the round-robin scans.
  always_comb begin
    ar_req = '0;
    aw_req = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ar_req[i] = ireqs[i].arvalid;
      aw_req[i] = ireqs[i].awvalid;
    end
  end

  assign r_pick    = rr_pick(ar_req, rptr_q);
  assign w_pick    = rr_pick(aw_req, wptr_q);
  assign ar_hs     = oreq.arvalid & oresp.arready;
  assign r_last_hs = oresp.rvalid & oreq.rready & oresp.rlast;
  assign aw_hs     = oreq.awvalid & oresp.awready;
  assign w_last_hs = oreq.wvalid & oresp.wready & oreq.wlast;
  assign b_hs      = oresp.bvalid & oreq.bready;

  assign rbusy = (r_state_q != R_IDLE);
  assign wbusy = (w_state_q != W_IDLE);
  assign rgnt  = rgnt_q;
  assign wgnt  = wgnt_q;

  // Read FSM next state: grant in IDLE, then address phase, then data until rlast.
  always_comb begin
    r_state_d = r_state_q;
    rgnt_d    = rgnt_q;
    rptr_d    = rptr_q;
    case (r_state_q)
      R_IDLE: if (r_pick[IDX_W]) begin
        rgnt_d    = r_pick[IDX_W-1:0];
        rptr_d    = rr_next(r_pick[IDX_W-1:0]);
        r_state_d = R_ADDR;
      end
      R_ADDR:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_last_hs) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state: AW and last W may complete in any order before B.
  always_comb begin
    w_state_d = w_state_q;
    wgnt_d    = wgnt_q;
    wptr_d    = wptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: if (w_pick[IDX_W]) begin
        wgnt_d    = w_pick[IDX_W-1:0];
        wptr_d    = rr_next(w_pick[IDX_W-1:0]);
        w_state_d = W_XFER;
      end
      W_XFER: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_last_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // State, grant and pointer registers for both channels.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      rgnt_q    <= '0;
      rptr_q    <= '0;
      w_state_q <= W_IDLE;
      wgnt_q    <= '0;
      wptr_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rgnt_q    <= rgnt_d;
      rptr_q    <= rptr_d;
      w_state_q <= w_state_d;
      wgnt_q    <= wgnt_d;
      wptr_q    <= wptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Route the granted requester to the shared port and responses back to it.
  // Address valids pass only while that address is still outstanding, so a
  // requester already raising its next arvalid/awvalid cannot issue twice.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rbusy && (rgnt_q == IDX_W'(i))) begin
        oreq.araddr       = ireqs[i].araddr;
        oreq.arlen        = ireqs[i].arlen;
        oreq.arvalid      = ireqs[i].arvalid & (r_state_q == R_ADDR);
        oreq.rready       = ireqs[i].rready;
        iresps[i].arready = oresp.arready;
        iresps[i].rdata   = oresp.rdata;
        iresps[i].rresp   = oresp.rresp;
        iresps[i].rlast   = oresp.rlast;
        iresps[i].rvalid  = oresp.rvalid;
      end
      if (wbusy && (wgnt_q == IDX_W'(i))) begin
        oreq.awaddr       = ireqs[i].awaddr;
        oreq.awlen        = ireqs[i].awlen;
        oreq.awvalid      = ireqs[i].awvalid & (w_state_q == W_XFER) & ~aw_done_q;
        oreq.wdata        = ireqs[i].wdata;
        oreq.wstrb        = ireqs[i].wstrb;
        oreq.wlast        = ireqs[i].wlast;
        oreq.wvalid       = ireqs[i].wvalid;
        oreq.bready       = ireqs[i].bready;
        iresps[i].awready = oresp.awready;
        iresps[i].wready  = oresp.wready;
        iresps[i].bresp   = oresp.bresp;
        iresps[i].bvalid  = oresp.bvalid;
      end
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Self-checking bench for axi_rr_arbiter with four requesters.
module tb_axi_rr_arbiter;
  import axi_rr_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             resetn;
  axi_req  [N-1:0]  ireqs;
  axi_resp          oresp;
  axi_resp [N-1:0]  iresps;
  axi_req           oreq;
  logic             rbusy, wbusy;
  logic [1:0]       rgnt, wgnt;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  int          gnt_q[$];

  axi_rr_arbiter #(.NUM_INPUTS(N)) dut (
    .clk   (clk),
    .resetn(resetn),
    .ireqs (ireqs),
    .oresp (oresp),
    .iresps(iresps),
    .oreq  (oreq),
    .rbusy (rbusy),
    .wbusy (wbusy),
    .rgnt  (rgnt),
    .wgnt  (wgnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    ireqs  = '0;
    oresp  = '0;
    exp_q.delete();
    gnt_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ireqs  = '0;
    for (int i = 0; i < N; i++) begin
      ireqs[i].arvalid = 1'b1;
      ireqs[i].awvalid = 1'b1;
      ireqs[i].wvalid  = 1'b1;
      ireqs[i].rready  = 1'b1;
    end
    oresp = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (oreq !== '0) begin bad++; $display("FAIL reset_oreq: got %h want 0", oreq); end
    total++;
    if (iresps !== '0) begin bad++; $display("FAIL reset_iresps: got %h want 0", iresps); end
    total++;
    if ({rbusy, wbusy, rgnt, wgnt} !== 6'b0) begin
      bad++; $display("FAIL reset_status: got %b want 000000", {rbusy, wbusy, rgnt, wgnt});
    end
    ireqs = '0;
    oresp = '0;
    step();
    resetn = 1'b1;
    step();
    @(negedge clk);
    total++;
    if ({rbusy, wbusy} !== 2'b00) begin bad++; $display("FAIL reset_idle: got %b want 00", {rbusy, wbusy}); end
  endtask

  task automatic test_single_read();
    apply_reset();
    ireqs[2].araddr  = 32'h2000_0040;
    ireqs[2].arvalid = 1'b1;
    ireqs[2].rready  = 1'b1;
    oresp.arready    = 1'b1;
    @(negedge clk);
    total++;
    if (oreq.arvalid !== 1'b0) begin bad++; $display("FAIL rd_latency: arvalid got %b want 0", oreq.arvalid); end
    step();
    @(negedge clk);
    total++;
    if ({rbusy, rgnt, oreq.arvalid} !== 4'b1_10_1) begin
      bad++; $display("FAIL rd_grant: got %b want 1101", {rbusy, rgnt, oreq.arvalid});
    end
    total++;
    if (oreq.araddr !== 32'h2000_0040) begin bad++; $display("FAIL rd_araddr: got %h want 20000040", oreq.araddr); end
    total++;
    if ({iresps[2].arready, iresps[0].arready} !== 2'b10) begin
      bad++; $display("FAIL rd_arready_route: got %b want 10", {iresps[2].arready, iresps[0].arready});
    end
    step();
    oresp.arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      oresp.rvalid = 1'b1;
      oresp.rdata  = 32'hD000_0000 + b;
      oresp.rlast  = (b == 3);
      exp_q.push_back(32'hD000_0000 + b);
      @(negedge clk);
      if (b == 0) begin
        total++;
        if (oreq.arvalid !== 1'b0) begin bad++; $display("FAIL rd_ar_forced: got %b want 0", oreq.arvalid); end
      end
      total++;
      if (iresps[2].rvalid !== 1'b1) begin
        bad++; $display("FAIL rd_beat%0d_valid: got %b want 1", b, iresps[2].rvalid);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        total++;
        if (iresps[2].rdata !== e) begin bad++; $display("FAIL rd_beat%0d_data: got %h want %h", b, iresps[2].rdata, e); end
      end
      total++;
      if (iresps[1] !== '0) begin bad++; $display("FAIL rd_beat%0d_other: got %h want 0", b, iresps[1]); end
      step();
      ireqs[2].arvalid = 1'b0;
    end
    oresp = '0;
    @(negedge clk);
    total++;
    if (rbusy !== 1'b0) begin bad++; $display("FAIL rd_release: rbusy got %b want 0", rbusy); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rd_scoreboard: left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_contention();
    int last_c;
    int grants;
    logic others_ok;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      ireqs[i].arvalid = 1'b1;
      ireqs[i].rready  = 1'b1;
      ireqs[i].araddr  = 32'(i) << 8;
      gnt_q.push_back(i);
    end
    gnt_q.push_back(0);
    oresp.arready = 1'b1;
    oresp.rvalid  = 1'b1;
    oresp.rlast   = 1'b1;
    oresp.rdata   = 32'hCAFE_0000;
    last_c = -1;
    grants = 0;
    for (int c = 0; c < 40 && grants < 5; c++) begin
      @(negedge clk);
      if (oreq.arvalid) begin
        int e;
        e = gnt_q.pop_front();
        total++;
        if (rgnt !== 2'(e)) begin bad++; $display("FAIL rr_order%0d: got %0d want %0d", grants, rgnt, e); end
        total++;
        if (oreq.araddr !== (32'(e) << 8)) begin bad++; $display("FAIL rr_addr%0d: got %h want %h", grants, oreq.araddr, 32'(e) << 8); end
        others_ok = 1'b1;
        for (int j = 0; j < N; j++)
          if (j != e && iresps[j] !== '0) others_ok = 1'b0;
        total++;
        if (!others_ok) begin bad++; $display("FAIL rr_others%0d: got nonzero want 0", grants); end
        if (last_c >= 0) begin
          total++;
          if (c - last_c != 3) begin bad++; $display("FAIL rr_gap%0d: got %0d want 3", grants, c - last_c); end
        end
        last_c = c;
        grants++;
      end
      step();
    end
    total++;
    if (grants != 5) begin bad++; $display("FAIL rr_count: got %0d want 5", grants); end
  endtask

  task automatic test_write_order();
    logic [31:0] e;
    apply_reset();
    ireqs[1].awaddr  = 32'h1000_0100;
    ireqs[1].awvalid = 1'b1;
    ireqs[1].wvalid  = 1'b1;
    ireqs[1].wdata   = 32'hAAAA_0001;
    ireqs[1].wstrb   = 4'hF;
    ireqs[1].wlast   = 1'b0;
    ireqs[1].bready  = 1'b1;
    oresp.wready     = 1'b1;
    exp_q.push_back(32'hAAAA_0001);
    @(negedge clk);
    total++;
    if ({wbusy, oreq.awvalid} !== 2'b00) begin bad++; $display("FAIL wr_latency: got %b want 00", {wbusy, oreq.awvalid}); end
    step();
    @(negedge clk);
    total++;
    if ({wbusy, wgnt, oreq.awvalid, oreq.wvalid} !== 5'b1_01_1_1) begin
      bad++; $display("FAIL wr_grant: got %b want 10111", {wbusy, wgnt, oreq.awvalid, oreq.wvalid});
    end
    e = exp_q.pop_front();
    total++;
    if (oreq.wdata !== e) begin bad++; $display("FAIL wr_beat0: got %h want %h", oreq.wdata, e); end
    step();
    ireqs[1].wdata = 32'hAAAA_0002;
    ireqs[1].wlast = 1'b1;
    exp_q.push_back(32'hAAAA_0002);
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if ({oreq.wdata, oreq.wlast} !== {e, 1'b1}) begin bad++; $display("FAIL wr_beat1: got %h want %h", {oreq.wdata, oreq.wlast}, {e, 1'b1}); end
    total++;
    if ({iresps[1].wready, iresps[0].wready} !== 2'b10) begin
      bad++; $display("FAIL wr_wready_route: got %b want 10", {iresps[1].wready, iresps[0].wready});
    end
    step();
    ireqs[1].wvalid = 1'b0;
    ireqs[1].wlast  = 1'b0;
    oresp.wready    = 1'b0;
    @(negedge clk);
    total++;
    if ({wbusy, oreq.awvalid} !== 2'b11) begin bad++; $display("FAIL wr_wait_aw: got %b want 11", {wbusy, oreq.awvalid}); end
    step();
    oresp.awready = 1'b1;
    @(negedge clk);
    total++;
    if (iresps[1].awready !== 1'b1) begin bad++; $display("FAIL wr_awready: got %b want 1", iresps[1].awready); end
    step();
    oresp.awready = 1'b0;
    @(negedge clk);
    total++;
    if (oreq.awvalid !== 1'b0) begin bad++; $display("FAIL wr_aw_forced: got %b want 0", oreq.awvalid); end
    step();
    step();
    oresp.bvalid = 1'b1;
    oresp.bresp  = 2'b10;
    @(negedge clk);
    total++;
    if ({iresps[1].bvalid, iresps[1].bresp, iresps[2].bvalid, oreq.bready, wbusy} !== 6'b1_10_0_1_1) begin
      bad++; $display("FAIL wr_bresp: got %b want 110011",
                      {iresps[1].bvalid, iresps[1].bresp, iresps[2].bvalid, oreq.bready, wbusy});
    end
    step();
    oresp            = '0;
    ireqs[1].awvalid = 1'b0;
    @(negedge clk);
    total++;
    if (wbusy !== 1'b0) begin bad++; $display("FAIL wr_release: wbusy got %b want 0", wbusy); end
  endtask

  task automatic test_concurrency();
    apply_reset();
    ireqs[0].araddr  = 32'h0000_8000;
    ireqs[0].arvalid = 1'b1;
    ireqs[0].rready  = 1'b1;
    ireqs[3].awaddr  = 32'h3000_0000;
    ireqs[3].awvalid = 1'b1;
    ireqs[3].wvalid  = 1'b1;
    ireqs[3].wlast   = 1'b1;
    ireqs[3].wdata   = 32'h3333_3333;
    ireqs[3].bready  = 1'b1;
    oresp.arready    = 1'b1;
    oresp.awready    = 1'b1;
    oresp.wready     = 1'b1;
    step();
    @(negedge clk);
    total++;
    if ({rbusy, wbusy, rgnt, wgnt} !== 6'b1_1_00_11) begin
      bad++; $display("FAIL cc_grant: got %b want 110011", {rbusy, wbusy, rgnt, wgnt});
    end
    total++;
    if ({oreq.araddr, oreq.awaddr} !== {32'h0000_8000, 32'h3000_0000}) begin
      bad++; $display("FAIL cc_addr: got %h want 0000800030000000", {oreq.araddr, oreq.awaddr});
    end
    total++;
    if ({iresps[3].arready, iresps[0].awready, iresps[0].wready} !== 3'b000) begin
      bad++; $display("FAIL cc_cross_ready: got %b want 000", {iresps[3].arready, iresps[0].awready, iresps[0].wready});
    end
    step();
    ireqs[0].arvalid = 1'b0;
    ireqs[3].awvalid = 1'b0;
    ireqs[3].wvalid  = 1'b0;
    ireqs[3].wlast   = 1'b0;
    oresp.arready    = 1'b0;
    oresp.awready    = 1'b0;
    oresp.wready     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      oresp.rvalid = 1'b1;
      oresp.rdata  = 32'h5150_0000 + k;
      oresp.rlast  = (k == 7);
      oresp.bvalid = (k == 2);
      exp_q.push_back(32'h5150_0000 + k);
      @(negedge clk);
      begin
        logic [31:0] e;
        e = exp_q.pop_front();
        total++;
        if ({iresps[0].rvalid, iresps[0].rdata} !== {1'b1, e}) begin
          bad++; $display("FAIL cc_rbeat%0d: got %h want %h", k, {iresps[0].rvalid, iresps[0].rdata}, {1'b1, e});
        end
      end
      total++;
      if (iresps[3].rvalid !== 1'b0) begin bad++; $display("FAIL cc_rcross%0d: got %b want 0", k, iresps[3].rvalid); end
      if (k == 2) begin
        total++;
        if ({iresps[3].bvalid, iresps[0].bvalid} !== 2'b10) begin
          bad++; $display("FAIL cc_bvalid: got %b want 10", {iresps[3].bvalid, iresps[0].bvalid});
        end
      end
      if (k == 3) begin
        total++;
        if ({rbusy, wbusy} !== 2'b10) begin bad++; $display("FAIL cc_indep: got %b want 10", {rbusy, wbusy}); end
      end
      step();
    end
    oresp = '0;
    @(negedge clk);
    total++;
    if (rbusy !== 1'b0) begin bad++; $display("FAIL cc_rrelease: got %b want 0", rbusy); end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    ireqs[0].arvalid = 1'b1;
    ireqs[0].rready  = 1'b1;
    oresp.arready    = 1'b1;
    step();
    step();
    ireqs[0].arvalid = 1'b0;
    oresp.arready    = 1'b0;
    oresp.rvalid     = 1'b1;
    oresp.rdata      = 32'h0BEA_7000;
    step();
    oresp.rdata = 32'h0BEA_7001;
    @(negedge clk);
    total++;
    if (iresps[0].rvalid !== 1'b1) begin bad++; $display("FAIL mid_beat2: got %b want 1", iresps[0].rvalid); end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({oreq, iresps} !== '0) begin bad++; $display("FAIL mid_zero: got oreq=%h iresps=%h want 0", oreq, iresps); end
    total++;
    if (rbusy !== 1'b0) begin bad++; $display("FAIL mid_rbusy: got %b want 0", rbusy); end
    step();
    resetn           = 1'b1;
    oresp            = '0;
    ireqs[0].arvalid = 1'b1;
    ireqs[1].arvalid = 1'b1;
    step();
    @(negedge clk);
    total++;
    if ({rbusy, rgnt} !== 3'b1_00) begin bad++; $display("FAIL mid_regrant: got %b want 100", {rbusy, rgnt}); end
  endtask

  initial begin
    resetn = 1'b0;
    ireqs  = '0;
    oresp  = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_order();
    test_concurrency();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rr_arbiter.md
# axi_rr_arbiter

Round-robin AXI arbiter sharing one AXI master port among `NUM_INPUTS` CPU-side requesters (I-cache, D-cache, uncached, etc.). It has independent read and write arbitration FSMs, so a read burst from one requester and a write burst from another can be in flight at the same time. Each grant is held until its transaction fully completes. The block sits between the cache/uncached units and the SoC AXI interface.

## Interface
- `NUM_INPUTS`, default 4: number of requesters, ≥ 1.
- `IDX_W`, default `$clog2(NUM_INPUTS)` (minimum 1): grant index width.
- `clk` in, 1: clock; all state changes on the rising edge.
- `resetn` in, 1: asynchronous, active-low reset.
- `ireqs` in, `axi_req [NUM_INPUTS-1:0]`: per-requester AXI requests with standard field names (`arvalid`, `rready`, `awvalid`, `wvalid`, `wlast`, `bready`, ...).
- `oresp` in, `axi_resp`: response from the shared port (`arready`, `rvalid`, `rlast`, `awready`, `wready`, `bvalid`, ...).
- `iresps` out, `axi_resp [NUM_INPUTS-1:0]`: per-requester responses.
- `oreq` out, `axi_req`: request to the shared port.
- `rbusy` out, 1: read channel granted.
- `wbusy` out, 1: write channel granted.
- `rgnt` out, `IDX_W`: read grant index; valid only when `rbusy=1`.
- `wgnt` out, `IDX_W`: write grant index; valid only when `wbusy=1`.

## Operation
- **Read FSM states:** R_IDLE, R_ADDR, R_DATA.
  - **R_IDLE:** scan requesters starting at `rptr` (`rptr`, `rptr+1`, ... mod N) for the first with `arvalid=1`. If one is found:
    - `rgnt` <= that index.
    - `rptr` <= index+1 mod N.
    - Go to R_ADDR.
  - **R_ADDR:** on `oreq.arvalid & oresp.arready`, go to R_DATA.
  - **R_DATA:** on `oresp.rvalid & oreq.rready & oresp.rlast`, go to R_IDLE.
- **Write FSM states:** W_IDLE, W_XFER, W_RESP.
  - **W_IDLE:** same round-robin scan on `awvalid`, using `wptr` and `wgnt`.
  - **W_XFER:** two internal flags, `aw_done` and `w_done`.
    - `aw_done` sets on the AW handshake.
    - `w_done` sets on a W handshake with `wlast`.
    - The two events may occur in either order or in the same cycle.
    - When both are set, or being set this cycle, go to W_RESP and clear both flags.
  - **W_RESP:** on `oresp.bvalid & oreq.bready`, go to W_IDLE.
- **Request muxing:**
  - `oreq` read-channel fields (AR, R-ready) are `ireqs[rgnt]` fields while `rbusy`; otherwise 0.
  - `oreq` write-channel fields (AW, W, B-ready) are `ireqs[wgnt]` fields while `wbusy`; otherwise 0.
- **Response muxing:**
  - `iresps[rgnt]` read fields = `oresp` read fields while `rbusy`.
  - `iresps[wgnt]` write fields = `oresp` write fields while `wbusy`.
  - All other `iresps` fields are 0. Ungranted requesters therefore never see `arready`, `awready`, `wready`, `rvalid` or `bvalid`.
- **In W_XFER after `aw_done`:** forced `oreq.awvalid=0`. This prevents a second AW from a requester that has already issued its next `awvalid`.
- **In R_DATA:** forced `oreq.arvalid=0`.
- **Single-requester case (N=1):** the round-robin pointer is degenerate; index is always 0.
- **Status outputs:** `rbusy` = (read state ≠ R_IDLE); `wbusy` = (write state ≠ W_IDLE).

## Timing
- **Reset** (async assert, synchronous-to-`clk` deassert usage):
  - Both FSMs go to IDLE.
  - `rptr` = `wptr` = 0; `rgnt` = `wgnt` = 0.
  - Flags cleared.
  - `oreq` = 0, `iresps` = 0, `rbusy` = `wbusy` = 0.
- **Reset mid-transaction:** immediate return to the reset state; no completion is emitted.
- **Grant latency:** `arvalid` sampled high in R_IDLE at edge N; `oreq.arvalid` is visible after edge N, in cycle N+1. Same for AW.
- **Release:** a last-beat R handshake or B handshake at edge M gives IDLE in cycle M+1. The earliest next grant is visible in cycle M+2, giving one idle cycle between transactions on a channel.
- **Simultaneous requests:** round-robin order only; the pointer advances past the granted index at grant time.
- **Request withdrawal:** a requester that drops `arvalid`/`awvalid` before grant is simply not selected. Dropping it after grant is a protocol violation; the FSM keeps waiting.
- **Cross-channel concurrency:** read and write FSMs are fully independent. The same requester may own both channels at once.

## Test plan
- **Single read:** requester 2 `arvalid` at cycle 0, 4-beat burst → `oreq.arvalid` in cycle 1, `rgnt=2`. `iresps[2]` receives 4 `rvalid` beats; `rbusy` falls the cycle after the `rlast` handshake.
- **Contention:** all 4 requesters hold `arvalid` from reset, each doing a 1-beat read → grant order is 0, 1, 2, 3, 0, with one idle cycle between grants. Non-granted `iresps` are all 0.
- **Write ordering:** requester 1 gives W beats (`wlast` on beat 2) before `awready` is asserted. Then the AW handshake occurs, then `bvalid` 3 cycles later → W_RESP is entered only after AW. `iresps[1].bvalid` is 1; `oreq.awvalid` is 0 after the AW handshake.
- **Concurrency:** requester 0 reads (8 beats) while requester 3 writes (1 beat) → both channels are granted in the same cycle, and both complete independently with no cross-routing.
- **Reset mid-op:** `resetn` pulsed low during R_DATA beat 2 → `oreq` and `iresps` go to 0 immediately; `rptr=0`; the next request from requester 0 is granted normally.
